// File: rtl/microwave_pkg.sv
// microwave_pkg: shared types and constants for the microwave cook timer
package microwave_pkg;
  typedef logic [3:0] bcd_t;
  typedef struct packed {
    bcd_t min_t;
    bcd_t min_o;
    bcd_t sec_t;
    bcd_t sec_o;
  } time_t;
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} timer_state_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t SEC_TENS_WRAP = 4'd5;
endpackage

// File: rtl/microwave_timer_if.sv
// microwave_timer_if: keypad, controller and display signals of the cook timer
interface microwave_timer_if;
  import microwave_pkg::*;
  logic clearn;
  logic digit_valid;
  bcd_t digit_in;
  logic count_en;
  logic timer_done;
  time_t time_bcd;
  logic time_zero;
  logic running;
  modport master (output clearn, digit_valid, digit_in, count_en,
                  input timer_done, time_bcd, time_zero, running);
  modport slave (input clearn, digit_valid, digit_in, count_en,
                 output timer_done, time_bcd, time_zero, running);
endinterface

// File: rtl/microwave_timer_bcd_down_digit.sv
// bcd_down_digit: one BCD digit decrementer, wrapping to a chosen value with borrow out
module bcd_down_digit
  import microwave_pkg::*;
(
  input  bcd_t d,
  input  bcd_t wrap,
  input  logic dec,
  output bcd_t q,
  output logic borrow
);
  assign borrow = dec && d == 4'd0;
  assign q = !dec ? d : (d == 4'd0 ? wrap : d - 4'd1);
endmodule

// File: rtl/microwave_timer.sv
// microwave_timer: keypad-entered MM:SS BCD countdown raising timer_done at 00:00
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int PRESC_W = 4
) (
  input logic clk,
  input logic rst,
  microwave_timer_if.slave bus
);
  timer_state_t state, state_n;
  time_t tm, tm_n, shifted;
  logic [PRESC_W-1:0] presc, presc_n;
  logic done, done_n, tick;
  logic [15:0] dec_time;
  logic [3:0] bor, dec_in;
  assign tick = state == RUN && bus.count_en && presc == PRESC_W'(TICKS_PER_SEC - 1);
  assign dec_in = {bor[2:0], tick};
  assign shifted = {tm[11:0], bus.digit_in};
  genvar i;
  for (i = 0; i < 4; i++) begin : g_dig
    bcd_down_digit u_dig (
      .d(tm[4*i +: 4]),
      .wrap(i == 1 ? SEC_TENS_WRAP : BCD_MAX),
      .dec(dec_in[i]),
      .q(dec_time[4*i +: 4]),
      .borrow(bor[i])
    );
  end
  // next state: clear beats digit entry beats countdown
  always_comb begin
    state_n = state;
    tm_n = tm;
    presc_n = presc;
    done_n = done;
    if (!bus.clearn) begin
      state_n = IDLE;
      tm_n = '0;
      presc_n = '0;
      done_n = 1'b0;
    end else if (bus.digit_valid && bus.digit_in <= BCD_MAX && state != RUN) begin
      tm_n = shifted;
      done_n = 1'b0;
      state_n = shifted != '0 ? ARMED : IDLE;
    end else if (state == ARMED && bus.count_en) begin
      state_n = RUN;
    end else if (state == RUN && !bus.count_en) begin
      state_n = ARMED;
    end else if (tick) begin
      presc_n = '0;
      tm_n = bor[3] ? tm : dec_time;
      if (dec_time == '0) begin
        state_n = DONE;
        done_n = 1'b1;
      end
    end else if (state == RUN) begin
      presc_n = presc + 1'b1;
    end
  end
  // state, time, prescaler and done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tm <= '0;
      presc <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      tm <= tm_n;
      presc <= presc_n;
      done <= done_n;
    end
  end
  assign bus.time_bcd = tm;
  assign bus.time_zero = tm == '0;
  assign bus.timer_done = done;
  assign bus.running = state == RUN;
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed scoreboard bench for the cook timer at 4 ticks per second
module tb_microwave_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  typedef struct {
    string name;
    logic [15:0] t;
    logic done;
    logic run;
  } exp_t;
  exp_t q[$];
  exp_t e;
  microwave_timer_if bus ();
  microwave_timer #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string n, input logic [15:0] t, input logic d, input logic r);
    q.push_back('{n, t, d, r});
  endtask
  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit_in = d;
    step(1);
    bus.digit_valid = 1'b0;
  endtask
  task automatic clear();
    bus.clearn = 1'b0;
    step(1);
    bus.clearn = 1'b1;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({bus.time_bcd, bus.timer_done, bus.running, bus.time_zero} !== {e.t, e.done, e.run, e.t == 16'h0}) begin
        fails++;
        $display("FAIL %s: got time=%h done=%b run=%b zero=%b, want time=%h done=%b run=%b zero=%b",
                 e.name, bus.time_bcd, bus.timer_done, bus.running, bus.time_zero,
                 e.t, e.done, e.run, e.t == 16'h0);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.clearn = 1'b1;
    bus.digit_valid = 1'b0;
    bus.digit_in = 4'd0;
    bus.count_en = 1'b0;
    step(2);
    expect_out("reset", 16'h0000, 0, 0);
    rst = 1'b0;
    key(1); key(3); key(0);
    expect_out("entry", 16'h0130, 0, 0);
    key(4'hC);
    expect_out("bad_digit", 16'h0130, 0, 0);
    clear();
    expect_out("clear_idle", 16'h0000, 0, 0);
    key(0); key(2);
    bus.count_en = 1'b1;
    step(1);
    expect_out("run_enter", 16'h0002, 0, 1);
    step(3);
    expect_out("before_tick", 16'h0002, 0, 1);
    step(1);
    expect_out("first_tick", 16'h0001, 0, 1);
    step(4);
    expect_out("expire", 16'h0000, 1, 0);
    step(3);
    expect_out("done_held", 16'h0000, 1, 0);
    bus.count_en = 1'b0;
    clear();
    key(1); key(0); key(0);
    bus.count_en = 1'b1;
    step(5);
    expect_out("min_borrow", 16'h0059, 0, 1);
    bus.count_en = 1'b0;
    clear();
    key(9); key(9);
    bus.count_en = 1'b1;
    step(1 + 4 * 39);
    expect_out("linear_99", 16'h0060, 0, 1);
    step(4);
    expect_out("linear_59", 16'h0059, 0, 1);
    bus.count_en = 1'b0;
    clear();
    key(5);
    bus.count_en = 1'b1;
    step(6);
    expect_out("pause_run", 16'h0004, 0, 1);
    step(1);
    bus.count_en = 1'b0;
    step(1);
    expect_out("paused", 16'h0004, 0, 0);
    step(10);
    expect_out("pause_hold", 16'h0004, 0, 0);
    bus.count_en = 1'b1;
    step(2);
    expect_out("resume_mid", 16'h0004, 0, 1);
    step(1);
    expect_out("resume_tick", 16'h0003, 0, 1);
    bus.count_en = 1'b0;
    clear();
    key(1); key(0);
    bus.count_en = 1'b1;
    step(3);
    expect_out("run_10", 16'h0010, 0, 1);
    clear();
    expect_out("clear_run", 16'h0000, 0, 0);
    key(1);
    expect_out("digit_over_count", 16'h0001, 0, 0);
    step(4);
    clear();
    expect_out("clear_expiry", 16'h0000, 0, 0);
    key(1);
    step(5);
    expect_out("done_again", 16'h0000, 1, 0);
    bus.count_en = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_out("reset_done", 16'h0000, 0, 0);
    key(1);
    bus.count_en = 1'b1;
    step(5);
    bus.count_en = 1'b0;
    expect_out("done_pre_digit", 16'h0000, 1, 0);
    key(7);
    expect_out("digit_in_done", 16'h0007, 0, 0);
    step(2);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
